// File: rtl/record_play_ctrl.sv
// record_play_ctrl
// Sequences record and playback between the codec stream bus and the sample
// memory. It takes one-cycle UI commands, writes incoming samples to memory
// while recording, and reads them back to the play stream while playing.
// It owns the memory word address and the recorded length.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start_rec, i_start_play, i_pause, i_stop
//                           one-cycle command pulses (priority stop > pause > rec > play)
//   rec_data/rec_valid/rec_ready      record stream in
//   play_data/play_valid/play_ready   play stream out
//   mem_addr/mem_wdata/mem_write/mem_read/mem_rdata/mem_waitrequest
//                           Avalon-style memory master
//   o_state                 0=IDLE 1=RECORD 2=PLAY 3=PAUSE
//   o_rec_len               number of samples held in memory
//   o_done                  one-cycle pulse on auto-stop
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no activity; waiting for start_rec / start_play
// RECORD  | taking record samples and writing them at mem_addr
// PLAY    | reading mem_addr and presenting the sample on the play stream
// PAUSE   | frozen at mem_addr; pause returns to RECORD or PLAY
module record_play_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int MAX_ADDR = 2**ADDR_W - 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_rec,
  input  logic              i_start_play,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [15:0]       rec_data,
  input  logic              rec_valid,
  output logic              rec_ready,
  output logic [15:0]       play_data,
  output logic              play_valid,
  input  logic              play_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_waitrequest,
  output logic [1:0]        o_state,
  output logic [ADDR_W:0]   o_rec_len,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2,
    S_PAUSE  = 2'd3
  } state_t;

  // Encoded so that a larger value means a higher priority.
  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_PLAY  = 3'd1,
    C_REC   = 3'd2,
    C_PAUSE = 3'd3,
    C_STOP  = 3'd4
  } cmd_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);
  localparam logic [ADDR_W:0]   ONE       = 1;

  state_t            state;
  cmd_t              pend;
  cmd_t              cmd_in;
  cmd_t              eff;
  logic              ret_play;
  logic              busy;
  logic              accept;
  logic [ADDR_W:0]   addr_next;

  always_comb begin
    cmd_in = C_NONE;
    if (i_stop)            cmd_in = C_STOP;
    else if (i_pause)      cmd_in = C_PAUSE;
    else if (i_start_rec)  cmd_in = C_REC;
    else if (i_start_play) cmd_in = C_PLAY;
  end

  assign eff       = (pend > cmd_in) ? pend : cmd_in;
  assign busy      = mem_write | mem_read;
  assign accept    = busy & ~mem_waitrequest;
  // One bit wider than the address so the end-of-playback compare works
  // when the whole memory has been recorded.
  assign addr_next = {1'b0, mem_addr} + ONE;

  // A pending command blocks new samples so it is applied before any new write.
  assign rec_ready = (state == S_RECORD) && !mem_write && (pend == C_NONE);
  assign o_state   = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      pend       <= C_NONE;
      ret_play   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      play_data  <= '0;
      play_valid <= 1'b0;
      o_rec_len  <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (busy) begin
        // Access in flight: hold the request, keep the strongest command.
        if (cmd_in > pend) pend <= cmd_in;
        if (accept) begin
          if (mem_write) begin
            mem_write <= 1'b0;
            o_rec_len <= addr_next;
            mem_addr  <= addr_next[ADDR_W-1:0];
            if (mem_addr == LAST_ADDR) begin
              o_done <= 1'b1;
              state  <= S_IDLE;
            end
          end else begin
            mem_read   <= 1'b0;
            play_data  <= mem_rdata;
            play_valid <= 1'b1;
          end
        end
      end else begin
        pend <= C_NONE;
        case (state)
          S_RECORD: begin
            if (rec_valid && rec_ready) begin
              mem_wdata <= rec_data;
              mem_write <= 1'b1;
              pend      <= cmd_in;
            end else if (eff == C_STOP) begin
              state <= S_IDLE;
            end else if (eff == C_PAUSE) begin
              state    <= S_PAUSE;
              ret_play <= 1'b0;
            end
          end
          S_PLAY: begin
            if (eff == C_STOP) begin
              play_valid <= 1'b0;
              state      <= S_IDLE;
            end else if (play_valid && play_ready) begin
              play_valid <= 1'b0;
              mem_addr   <= addr_next[ADDR_W-1:0];
              if (addr_next == o_rec_len) begin
                o_done <= 1'b1;
                state  <= S_IDLE;
              end else if (eff == C_PAUSE) begin
                state    <= S_PAUSE;
                ret_play <= 1'b1;
              end else begin
                mem_read <= 1'b1;
              end
            end else if (eff == C_PAUSE) begin
              // Pause waits until the presented sample has been taken.
              pend <= C_PAUSE;
            end
          end
          default: begin
            // IDLE and PAUSE share the start behaviour.
            if (state == S_PAUSE && eff == C_STOP) begin
              state <= S_IDLE;
            end else if (state == S_PAUSE && eff == C_PAUSE) begin
              if (ret_play) begin
                state    <= S_PLAY;
                mem_read <= 1'b1;
              end else begin
                state <= S_RECORD;
              end
            end else if (eff == C_REC) begin
              mem_addr  <= '0;
              o_rec_len <= '0;
              state     <= S_RECORD;
            end else if (eff == C_PLAY && o_rec_len != '0) begin
              mem_addr <= '0;
              mem_read <= 1'b1;
              state    <= S_PLAY;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_record_play_ctrl.sv
// tb_record_play_ctrl
// Self-checking bench for record_play_ctrl with an 8-word memory (ADDR_W=3).
// A behavioural memory and stream model lives in cyc(); each test task drives
// its scenario and compares against samples the bench itself handed over.
module tb_record_play_ctrl;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          i_rst, i_start_rec, i_start_play, i_pause, i_stop;
  logic [15:0]   rec_data;
  logic          rec_valid, rec_ready;
  logic [15:0]   play_data;
  logic          play_valid, play_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_write, mem_read;
  logic [15:0]   mem_rdata;
  logic          mem_waitrequest;
  logic [1:0]    o_state;
  logic [AW:0]   o_rec_len;
  logic          o_done;

  record_play_ctrl #(.ADDR_W(AW), .MAX_ADDR(7)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start_rec(i_start_rec), .i_start_play(i_start_play),
    .i_pause(i_pause), .i_stop(i_stop), .rec_data(rec_data), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .play_data(play_data), .play_valid(play_valid),
    .play_ready(play_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_waitrequest(mem_waitrequest), .o_state(o_state), .o_rec_len(o_rec_len),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_arr [0:7];
  int          wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] played_q[$];
  logic [15:0] acc_q[$];
  int          rd_cnt, last_rd_addr, done_cnt;
  logic [1:0]  done_state;
  bit          rand_wait = 0, rand_ready = 0;

  // One clock cycle: log what the memory/stream see at the coming edge,
  // then advance to just after the edge and refresh the random inputs.
  task automatic cyc();
    if (o_done) begin done_cnt++; done_state = o_state; end
    if (mem_write && !mem_waitrequest) begin
      mem_arr[mem_addr] = mem_wdata;
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (mem_read && !mem_waitrequest) begin rd_cnt++; last_rd_addr = int'(mem_addr); end
    if (play_valid && play_ready) played_q.push_back(play_data);
    @(posedge clk); #1;
    if (rand_wait)  mem_waitrequest = ($urandom_range(0, 3) == 0);
    if (rand_ready) play_ready = ($urandom_range(0, 1) == 1);
    mem_rdata = mem_arr[mem_addr];
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); played_q.delete();
    rd_cnt = 0; last_rd_addr = -1; done_cnt = 0; done_state = 2'd0;
  endtask

  task automatic pulse(input bit s, input bit p, input bit r, input bit pl);
    i_stop = s; i_pause = p; i_start_rec = r; i_start_play = pl;
    cyc();
    i_stop = 0; i_pause = 0; i_start_rec = 0; i_start_play = 0;
  endtask

  task automatic send_sample(input logic [15:0] d, input int budget, output bit ok);
    ok = 0; rec_valid = 1; rec_data = d;
    for (int i = 0; i < budget && !ok; i++) begin
      if (rec_ready) ok = 1;
      cyc();
    end
    rec_valid = 0;
  endtask

  task automatic test_reset();
    i_rst = 1; i_start_rec = 0; i_start_play = 0; i_pause = 0; i_stop = 0;
    rec_data = 0; rec_valid = 0; play_ready = 0; mem_rdata = 0; mem_waitrequest = 0;
    for (int i = 0; i < 8; i++) mem_arr[i] = 16'h0;
    repeat (3) cyc();
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    checks++; if ({rec_ready, play_valid, mem_write, mem_read, o_done} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {rec_ready, play_valid, mem_write, mem_read, o_done}); end
    checks++; if ({mem_addr, mem_wdata, play_data, o_rec_len} !== '0) begin
      errors++; $display("FAIL reset_regs: addr %0h wdata %0h pdata %0h len %0d expected all 0", mem_addr, mem_wdata, play_data, o_rec_len); end
    i_rst = 0;
    cyc();
  endtask

  task automatic test_record_basic();
    bit ok;
    clear_logs();
    pulse(0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      send_sample(16'(k), 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rec_accept: sample %0d not taken, expected taken", k); end
      checks++; if ({mem_write, rec_ready} !== 2'b10) begin
        errors++; $display("FAIL rec_timing: write/ready %b expected 10", {mem_write, rec_ready}); end
    end
    pulse(1, 0, 0, 0);
    repeat (3) cyc();
    checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL rec_nwrites: got %0d expected 4", wr_addr_q.size()); end
    for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
      checks++; if (wr_addr_q[k] != k || wr_data_q[k] !== 16'(k + 1)) begin
        errors++; $display("FAIL rec_write: addr %0d data %0h expected addr %0d data %0h", wr_addr_q[k], wr_data_q[k], k, k + 1); end
    end
    checks++; if (o_rec_len !== 4'd4 || o_state !== 2'd0) begin
      errors++; $display("FAIL rec_end: len %0d state %0d expected len 4 state 0", o_rec_len, o_state); end
  endtask

  task automatic test_playback();
    clear_logs();
    play_ready = 1;
    pulse(0, 0, 0, 1);
    for (int i = 0; i < 100 && done_cnt == 0; i++) cyc();
    repeat (3) cyc();
    checks++; if (played_q.size() != 4) begin errors++; $display("FAIL play_count: got %0d expected 4", played_q.size()); end
    for (int k = 0; k < 4 && k < played_q.size(); k++) begin
      checks++; if (played_q[k] !== 16'(k + 1)) begin
        errors++; $display("FAIL play_data: index %0d got %0h expected %0h", k, played_q[k], k + 1); end
    end
    checks++; if (done_cnt != 1 || done_state !== 2'd0) begin
      errors++; $display("FAIL play_done: pulses %0d state %0d expected 1 pulse with state 0", done_cnt, done_state); end
    checks++; if (rd_cnt != 4 || last_rd_addr != 3) begin
      errors++; $display("FAIL play_reads: count %0d last %0d expected 4 and 3", rd_cnt, last_rd_addr); end
    play_ready = 0;
  endtask

  task automatic test_stall_stop();
    bit ok;
    clear_logs();
    pulse(0, 0, 1, 0);
    send_sample(16'hA001, 20, ok);
    send_sample(16'hA002, 20, ok);
    mem_waitrequest = 1;
    for (int i = 0; i < 5; i++) begin
      i_stop = (i == 1);
      cyc();
      i_stop = 0;
      checks++; if (mem_write !== 1'b1 || mem_addr !== 3'd1 || mem_wdata !== 16'hA002 || o_state !== 2'd1) begin
        errors++; $display("FAIL stall_hold: wr %b addr %0d data %0h state %0d expected 1 1 a002 1", mem_write, mem_addr, mem_wdata, o_state); end
    end
    mem_waitrequest = 0;
    repeat (4) cyc();
    checks++; if (wr_addr_q.size() != 2 || wr_addr_q[wr_addr_q.size()-1] != 1 || wr_data_q[wr_data_q.size()-1] !== 16'hA002) begin
      errors++; $display("FAIL stall_write: %0d writes, expected 2 ending at addr 1 with a002", wr_addr_q.size()); end
    checks++; if (o_state !== 2'd0 || o_rec_len !== 4'd2) begin
      errors++; $display("FAIL stall_end: state %0d len %0d expected 0 and 2", o_state, o_rec_len); end
  endtask

  task automatic test_play_stall();
    int rd0;
    clear_logs();
    play_ready = 0;
    pulse(0, 0, 0, 1);
    for (int i = 0; i < 20 && !play_valid; i++) cyc();
    checks++; if (play_valid !== 1'b1 || play_data !== 16'hA001) begin
      errors++; $display("FAIL pstall_first: valid %b data %0h expected 1 a001", play_valid, play_data); end
    rd0 = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if (play_valid !== 1'b1 || play_data !== 16'hA001 || mem_read !== 1'b0) begin
        errors++; $display("FAIL pstall_hold: valid %b data %0h read %b expected 1 a001 0", play_valid, play_data, mem_read); end
    end
    checks++; if (rd_cnt != rd0) begin errors++; $display("FAIL pstall_reads: got %0d expected %0d", rd_cnt, rd0); end
    pulse(1, 0, 0, 0);
    checks++; if (o_state !== 2'd0 || play_valid !== 1'b0 || o_rec_len !== 4'd2) begin
      errors++; $display("FAIL pstall_stop: state %0d valid %b len %0d expected 0 0 2", o_state, play_valid, o_rec_len); end
  endtask

  task automatic test_autostop();
    bit ok;
    clear_logs(); acc_q.delete();
    rand_wait = 1;
    pulse(0, 0, 1, 0);
    for (int k = 0; k < 9; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      send_sample(d, 40, ok);
      if (ok) acc_q.push_back(d);
    end
    rand_wait = 0; mem_waitrequest = 0;
    repeat (3) cyc();
    checks++; if (acc_q.size() != 8 || wr_addr_q.size() != 8) begin
      errors++; $display("FAIL auto_count: accepted %0d written %0d expected 8 8", acc_q.size(), wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size() && k < acc_q.size(); k++) begin
      checks++; if (wr_addr_q[k] != k || wr_data_q[k] !== acc_q[k]) begin
        errors++; $display("FAIL auto_write: addr %0d data %0h expected addr %0d data %0h", wr_addr_q[k], wr_data_q[k], k, acc_q[k]); end
    end
    checks++; if (done_cnt != 1 || done_state !== 2'd0) begin
      errors++; $display("FAIL auto_done: pulses %0d state %0d expected 1 and 0", done_cnt, done_state); end
    checks++; if (o_rec_len !== 4'd8 || rec_ready !== 1'b0 || o_state !== 2'd0) begin
      errors++; $display("FAIL auto_end: len %0d ready %b state %0d expected 8 0 0", o_rec_len, rec_ready, o_state); end
  endtask

  task automatic test_random_play(input bit with_pause);
    int paused = 0, pcnt = 0;
    bit req = 0;
    logic [AW-1:0] hold_addr;
    clear_logs();
    rand_wait = 1; rand_ready = 1;
    pulse(0, 0, 0, 1);
    hold_addr = '0;
    for (int i = 0; i < 1500 && done_cnt == 0; i++) begin
      if (with_pause && o_state == 2'd2 && !req && (paused == 0 || $urandom_range(0, 3) == 0)) begin
        i_pause = 1; req = 1;
      end else if (with_pause && o_state == 2'd3) begin
        if (pcnt == 0) hold_addr = mem_addr;
        paused++;
        checks++; if (play_valid !== 1'b0 || mem_read !== 1'b0 || mem_addr !== hold_addr) begin
          errors++; $display("FAIL pause_quiet: valid %b read %b addr %0d expected 0 0 %0d", play_valid, mem_read, mem_addr, hold_addr); end
        pcnt++;
        if (pcnt == 3) begin i_pause = 1; pcnt = 0; req = 0; end
      end
      cyc();
      i_pause = 0;
    end
    rand_wait = 0; rand_ready = 0; mem_waitrequest = 0; play_ready = 0;
    repeat (2) cyc();
    checks++; if (played_q.size() != acc_q.size()) begin
      errors++; $display("FAIL rplay_count: got %0d expected %0d", played_q.size(), acc_q.size()); end
    for (int k = 0; k < played_q.size() && k < acc_q.size(); k++) begin
      checks++; if (played_q[k] !== acc_q[k]) begin
        errors++; $display("FAIL rplay_data: index %0d got %0h expected %0h", k, played_q[k], acc_q[k]); end
    end
    checks++; if (done_cnt != 1 || rd_cnt != 8 || last_rd_addr != 7) begin
      errors++; $display("FAIL rplay_end: done %0d reads %0d last %0d expected 1 8 7", done_cnt, rd_cnt, last_rd_addr); end
    if (with_pause) begin
      checks++; if (paused == 0) begin errors++; $display("FAIL pause_entered: got 0 pause cycles expected some"); end
    end
    checks++; if (o_rec_len !== 4'd8) begin errors++; $display("FAIL rplay_len: got %0d expected 8", o_rec_len); end
  endtask

  task automatic test_pause_record();
    bit ok;
    clear_logs();
    pulse(0, 0, 1, 0);
    send_sample(16'hB001, 20, ok);
    send_sample(16'hB002, 20, ok);
    pulse(0, 1, 0, 0);
    for (int i = 0; i < 10 && o_state != 2'd3; i++) cyc();
    checks++; if (o_state !== 2'd3 || rec_ready !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL rpause_enter: state %0d ready %b write %b expected 3 0 0", o_state, rec_ready, mem_write); end
    repeat (3) cyc();
    checks++; if (mem_addr !== 3'd2) begin errors++; $display("FAIL rpause_addr: got %0d expected 2", mem_addr); end
    pulse(0, 1, 0, 0);
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL rpause_resume: state %0d expected 1", o_state); end
    send_sample(16'hB003, 20, ok);
    pulse(1, 0, 0, 0);
    repeat (3) cyc();
    checks++; if (o_rec_len !== 4'd3 || wr_addr_q.size() != 3) begin
      errors++; $display("FAIL rpause_len: len %0d writes %0d expected 3 3", o_rec_len, wr_addr_q.size()); end
    for (int k = 0; k < 3 && k < wr_addr_q.size(); k++) begin
      checks++; if (wr_addr_q[k] != k || wr_data_q[k] !== 16'hB001 + 16'(k)) begin
        errors++; $display("FAIL rpause_write: addr %0d data %0h expected addr %0d data %0h", wr_addr_q[k], wr_data_q[k], k, 16'hB001 + 16'(k)); end
    end
  endtask

  task automatic test_priority();
    play_ready = 0;
    pulse(0, 0, 0, 1);
    for (int i = 0; i < 20 && !play_valid; i++) cyc();
    pulse(1, 1, 0, 0);
    checks++; if (o_state !== 2'd0 || play_valid !== 1'b0 || o_rec_len !== 4'd3) begin
      errors++; $display("FAIL prio_stop: state %0d valid %b len %0d expected 0 0 3", o_state, play_valid, o_rec_len); end
    pulse(0, 1, 1, 0);
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL prio_pause_idle: state %0d expected 0", o_state); end
    pulse(0, 0, 1, 1);
    checks++; if (o_state !== 2'd1 || o_rec_len !== 4'd0) begin
      errors++; $display("FAIL prio_rec: state %0d len %0d expected 1 0", o_state, o_rec_len); end
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    repeat (3) cyc();
    checks++; if (o_state !== 2'd0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL prio_empty_play: state %0d read %b expected 0 0", o_state, mem_read); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse(0, 0, 1, 0);
    mem_waitrequest = 1;
    send_sample(16'hC001, 20, ok);
    cyc();
    i_rst = 1;
    cyc();
    checks++; if (mem_write !== 1'b0 || o_state !== 2'd0 || rec_ready !== 1'b0 || mem_addr !== 3'd0) begin
      errors++; $display("FAIL rst_mid: write %b state %0d ready %b addr %0d expected 0 0 0 0", mem_write, o_state, rec_ready, mem_addr); end
    i_rst = 0; mem_waitrequest = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_record_basic();
    test_playback();
    test_stall_stop();
    test_play_stall();
    test_autostop();
    test_random_play(0);
    test_random_play(1);
    test_pause_record();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
